// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller and its line store.
// Holds the default widths shared with the main-memory model, the memory
// command encoding, the controller FSM state encoding and a saturating
// counter helper.
package cache_ctrl_pkg;

  localparam int DEF_WORDSIZE         = 32;
  localparam int DEF_ADDRESSBIT       = 16;
  localparam int DEF_MEM_ACCESS_DELAY = 3;

  // Memory / CPU command encoding.
  localparam logic RD = 1'b0;
  localparam logic WT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cacheState_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cache_ctrl_line_store.sv
// cache_line_store: valid/tag/data arrays of a direct-mapped cache with one
// word per line.
// Ports:
//   clk      in   clock
//   clearAll in   synchronous clear of every valid bit (has priority)
//   rdIndex  in   combinational read port index
//   rdValid  out  valid bit of the addressed line
//   rdTag    out  tag of the addressed line
//   rdData   out  data word of the addressed line
//   wrEn     in   synchronous write enable; a write also marks the line valid
//   wrIndex  in   write port index
//   wrTag    in   tag to store
//   wrData   in   data word to store
module cache_line_store #(
  parameter int INDEXBIT = 4,
  parameter int TAGBIT   = 12,
  parameter int WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                clearAll,
  input  logic [INDEXBIT-1:0] rdIndex,
  output logic                rdValid,
  output logic [TAGBIT-1:0]   rdTag,
  output logic [WORDSIZE-1:0] rdData,
  input  logic                wrEn,
  input  logic [INDEXBIT-1:0] wrIndex,
  input  logic [TAGBIT-1:0]   wrTag,
  input  logic [WORDSIZE-1:0] wrData
);

  localparam int LINES = 1 << INDEXBIT;

  logic [LINES-1:0]    validBits;
  logic [TAGBIT-1:0]   tagMem  [LINES];
  logic [WORDSIZE-1:0] dataMem [LINES];

  assign rdValid = validBits[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdData  = dataMem[rdIndex];

  // Only the valid bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (clearAll) begin
      validBits <= '0;
    end else if (wrEn) begin
      validBits[wrIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIndex]  <= wrTag;
      dataMem[wrIndex] <= wrData;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, read-allocate L1 cache controller,
// one word per line, sitting between a CPU request port and one port of the
// main-memory model. Each memory command is held stable for MEM_WAIT cycles
// and then treated as complete.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cpu_req/rdwt/addr/wdata  CPU request (held stable until cpu_ready)
//   cpu_rdata, cpu_ready  read data and one-cycle completion pulse
//   mem_addr/rdwt/wdata   memory command (registered)
//   mem_rdata             memory read data
//   hit_count, miss_count saturating read-hit / read-miss counters
//   dbgState              current FSM state, for observation only
//
// Handshake: a request is accepted on the first rising edge where cpu_req=1,
// the FSM is IDLE and cpu_ready=0. The CPU keeps cpu_req, cpu_rdwt, cpu_addr
// and cpu_wdata stable until it sees cpu_ready=1, which lasts exactly one
// cycle; cpu_req is ignored during that cycle so the same request is never
// accepted twice. Once accepted, an operation completes even if cpu_req drops.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDRESSBIT       = DEF_ADDRESSBIT,
  parameter int WORDSIZE         = DEF_WORDSIZE,
  parameter int INDEXBIT         = 4,
  parameter int MEM_ACCESS_DELAY = DEF_MEM_ACCESS_DELAY,
  parameter int MEM_WAIT         = MEM_ACCESS_DELAY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_rdwt,
  input  logic [ADDRESSBIT-1:0] cpu_addr,
  input  logic [WORDSIZE-1:0]   cpu_wdata,
  output logic [WORDSIZE-1:0]   cpu_rdata,
  output logic                  cpu_ready,
  output logic [ADDRESSBIT-1:0] mem_addr,
  output logic                  mem_rdwt,
  output logic [WORDSIZE-1:0]   mem_wdata,
  input  logic [WORDSIZE-1:0]   mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
  output logic [1:0]            dbgState
);

  localparam int TAGBIT  = ADDRESSBIT - INDEXBIT;
  localparam int WAITBIT = $clog2(MEM_WAIT + 1);
  localparam logic [WAITBIT-1:0] WAIT_LOAD = WAITBIT'(MEM_WAIT - 1);

  cacheState_t state, stateNext;
  logic [WAITBIT-1:0] waitCnt, waitNext;

  logic [WORDSIZE-1:0]   rdataNext;
  logic                  readyNext;
  logic [ADDRESSBIT-1:0] memAddrNext;
  logic                  memRdwtNext;
  logic [WORDSIZE-1:0]   memWdataNext;
  logic [15:0]           hitNext, missNext;

  logic [INDEXBIT-1:0] reqIdx;
  logic [TAGBIT-1:0]   reqTag;
  logic                lineValid;
  logic [TAGBIT-1:0]   lineTag;
  logic [WORDSIZE-1:0] lineData;
  logic                lineHit;

  logic                wrEn;
  logic [INDEXBIT-1:0] wrIndex;
  logic [TAGBIT-1:0]   wrTag;
  logic [WORDSIZE-1:0] wrData;

  assign reqIdx   = cpu_addr[INDEXBIT-1:0];
  assign reqTag   = cpu_addr[ADDRESSBIT-1:INDEXBIT];
  assign lineHit  = lineValid && (lineTag == reqTag);
  assign dbgState = state;

  cache_line_store #(
    .INDEXBIT (INDEXBIT),
    .TAGBIT   (TAGBIT),
    .WORDSIZE (WORDSIZE)
  ) u_store (
    .clk      (clk),
    .clearAll (rst),
    .rdIndex  (reqIdx),
    .rdValid  (lineValid),
    .rdTag    (lineTag),
    .rdData   (lineData),
    .wrEn     (wrEn),
    .wrIndex  (wrIndex),
    .wrTag    (wrTag),
    .wrData   (wrData)
  );

  always_comb begin
    stateNext    = state;
    waitNext     = waitCnt;
    rdataNext    = cpu_rdata;
    readyNext    = 1'b0;
    memAddrNext  = mem_addr;
    memRdwtNext  = mem_rdwt;
    memWdataNext = mem_wdata;
    hitNext      = hit_count;
    missNext     = miss_count;
    wrEn         = 1'b0;
    wrIndex      = reqIdx;
    wrTag        = reqTag;
    wrData       = cpu_wdata;

    case (state)
      IDLE: begin
        if (cpu_req && !cpu_ready) begin
          if (cpu_rdwt == RD) begin
            if (lineHit) begin
              rdataNext = lineData;
              readyNext = 1'b1;
              hitNext   = satInc(hit_count);
            end else begin
              memAddrNext = cpu_addr;
              memRdwtNext = RD;
              waitNext    = WAIT_LOAD;
              missNext    = satInc(miss_count);
              stateNext   = FILL;
            end
          end else begin
            memAddrNext  = cpu_addr;
            memWdataNext = cpu_wdata;
            memRdwtNext  = WT;
            waitNext     = WAIT_LOAD;
            stateNext    = WRITE;
            // Write hit refreshes the cached copy; a write miss allocates nothing.
            wrEn         = lineHit;
          end
        end
      end

      FILL: begin
        if (waitCnt == '0) begin
          // The held memory address is the request address; use it for the fill.
          wrEn      = 1'b1;
          wrIndex   = mem_addr[INDEXBIT-1:0];
          wrTag     = mem_addr[ADDRESSBIT-1:INDEXBIT];
          wrData    = mem_rdata;
          rdataNext = mem_rdata;
          readyNext = 1'b1;
          stateNext = IDLE;
        end else begin
          waitNext = waitCnt - 1'b1;
        end
      end

      WRITE: begin
        if (waitCnt == '0) begin
          readyNext   = 1'b1;
          // Park the memory on a read so the write is not repeated.
          memRdwtNext = RD;
          stateNext   = IDLE;
        end else begin
          waitNext = waitCnt - 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase

    // Reset aborts everything, including any pending array update.
    if (rst) begin
      wrEn = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      mem_addr   <= '0;
      mem_rdwt   <= RD;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitNext;
      cpu_rdata  <= rdataNext;
      cpu_ready  <= readyNext;
      mem_addr   <= memAddrNext;
      mem_rdwt   <= memRdwtNext;
      mem_wdata  <= memWdataNext;
      hit_count  <= hitNext;
      miss_count <= missNext;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl with INDEXBIT=2, MEM_ACCESS_DELAY=3 (MEM_WAIT=5)
// and a main-memory model preloaded with mem[k] = k + 16'h100.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IB = 2;
  localparam int MAD = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req;
  logic          cpu_rdwt;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rdwt;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
  logic [1:0]    dbgState;

  cache_ctrl #(
    .ADDRESSBIT       (AW),
    .WORDSIZE         (DW),
    .INDEXBIT         (IB),
    .MEM_ACCESS_DELAY (MAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_rdwt   (cpu_rdwt),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_addr   (mem_addr),
    .mem_rdwt   (mem_rdwt),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbgState   (dbgState)
  );

  // ---------------- main-memory model ----------------
  // A command change reloads the delay counter; the access happens when the
  // counter runs out while the command is still unchanged.
  logic [DW-1:0] mainMem [0:65535];
  bit            memLoaded;
  logic [AW-1:0] lastAddr;
  logic          lastRdwt;
  logic [DW-1:0] lastWdata;
  int            memCnt;

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int k = 0; k < 65536; k++) mainMem[k] <= DW'(k) + 32'h100;
      memLoaded <= 1'b1;
      lastAddr  <= mem_addr;
      lastRdwt  <= mem_rdwt;
      lastWdata <= mem_wdata;
      memCnt    <= 0;
    end else if (mem_addr !== lastAddr || mem_rdwt !== lastRdwt || mem_wdata !== lastWdata) begin
      lastAddr  <= mem_addr;
      lastRdwt  <= mem_rdwt;
      lastWdata <= mem_wdata;
      memCnt    <= MAD;
    end else if (memCnt > 1) begin
      memCnt <= memCnt - 1;
    end else if (memCnt == 1) begin
      memCnt <= 0;
      if (mem_rdwt == WT) begin
        mainMem[mem_addr] <= mem_wdata;
        mem_rdata         <= mem_wdata;
      end else begin
        mem_rdata <= mainMem[mem_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- driver ----------------
  // Drives one request and waits (bounded) for cpu_ready. lat counts rising
  // edges from the accepting edge (1 = accepted and answered on the same edge);
  // -1 means no response arrived. wtCycles counts busy cycles with a write
  // command on the memory port; cmdChanges counts memory-command changes while busy.
  task automatic drive_op(input logic rdwt, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output int lat, output logic [DW-1:0] rdata,
                          output int wtCycles, output int cmdChanges);
    logic [AW-1:0] a0;
    logic          r0;
    logic [DW-1:0] w0;
    bit            first;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rdwt  = rdwt;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat        = -1;
    rdata      = '0;
    wtCycles   = 0;
    cmdChanges = 0;
    first      = 1'b1;
    a0 = '0; r0 = 1'b0; w0 = '0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) begin
        lat   = c;
        rdata = cpu_rdata;
        break;
      end
      if (mem_rdwt == WT) wtCycles++;
      if (first) begin
        a0 = mem_addr; r0 = mem_rdwt; w0 = mem_wdata;
        first = 1'b0;
      end else if (mem_addr !== a0 || mem_rdwt !== r0 || mem_wdata !== w0) begin
        cmdChanges++;
      end
    end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Read with scoreboard: expected data pushed before driving, popped on response.
  task automatic scored_read(input string name, input logic [AW-1:0] addr,
                             input logic [DW-1:0] expData, input int expLat);
    int            lat, wtc, chg;
    logic [DW-1:0] rdata;
    logic [DW-1:0] expect_v;
    exp_q.push_back(expData);
    drive_op(RD, addr, '0, lat, rdata, wtc, chg);
    expect_v = exp_q.pop_front();
    total++;
    if (rdata !== expect_v) begin
      bad++;
      $display("FAIL %s_data addr=%h got=%h exp=%h", name, addr, rdata, expect_v);
    end
    total++;
    if (lat !== expLat) begin
      bad++;
      $display("FAIL %s_latency addr=%h got=%0d exp=%0d", name, addr, lat, expLat);
    end
    total++;
    if (wtc !== 0 || chg !== 0) begin
      bad++;
      $display("FAIL %s_memcmd addr=%h wt_cycles=%0d changes=%0d exp=0/0", name, addr, wtc, chg);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== '0 || dbgState !== 2'(IDLE)) begin
      bad++;
      $display("FAIL reset_cpu ready=%b rdata=%h state=%0d exp=0/0/0", cpu_ready, cpu_rdata, dbgState);
    end
    total++;
    if (mem_addr !== '0 || mem_rdwt !== RD || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_mem addr=%h rdwt=%b wdata=%h exp=0/0/0", mem_addr, mem_rdwt, mem_wdata);
    end
    total++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters hit=%0d miss=%0d exp=0/0", hit_count, miss_count);
    end
  endtask

  task automatic test_read_miss();
    scored_read("miss_0010", 16'h0010, 32'h110, 6);
    total++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL miss_counters hit=%0d miss=%0d exp=0/1", hit_count, miss_count);
    end
  endtask

  task automatic test_read_hit();
    scored_read("hit_0010", 16'h0010, 32'h110, 1);
    total++;
    if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      bad++;
      $display("FAIL hit_counters hit=%0d miss=%0d exp=1/1", hit_count, miss_count);
    end
    total++;
    if (mem_addr !== 16'h0010) begin
      bad++;
      $display("FAIL hit_mem_addr got=%h exp=0010", mem_addr);
    end
  endtask

  task automatic test_write_hit();
    int            lat, wtc, chg;
    logic [DW-1:0] rdata;
    drive_op(WT, 16'h0010, 32'hAB, lat, rdata, wtc, chg);
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL write_latency got=%0d exp=6", lat);
    end
    total++;
    if (wtc !== 5 || chg !== 0) begin
      bad++;
      $display("FAIL write_memcmd wt_cycles=%0d changes=%0d exp=5/0", wtc, chg);
    end
    total++;
    if (mainMem[16'h0010] !== 32'hAB) begin
      bad++;
      $display("FAIL write_mem_commit got=%h exp=000000ab", mainMem[16'h0010]);
    end
    total++;
    if (mem_rdwt !== RD) begin
      bad++;
      $display("FAIL write_idle_rd got=%b exp=0", mem_rdwt);
    end
    scored_read("hit_after_write", 16'h0010, 32'hAB, 1);
    total++;
    if (hit_count !== 16'd2 || miss_count !== 16'd1) begin
      bad++;
      $display("FAIL write_counters hit=%0d miss=%0d exp=2/1", hit_count, miss_count);
    end
  endtask

  task automatic test_conflict();
    scored_read("conflict_0014", 16'h0014, 32'h114, 6);
    scored_read("conflict_0010", 16'h0010, 32'hAB, 6);
    total++;
    if (miss_count !== 16'd3) begin
      bad++;
      $display("FAIL conflict_miss_count got=%0d exp=3", miss_count);
    end
  endtask

  task automatic test_write_miss();
    int            lat, wtc, chg;
    logic [DW-1:0] rdata;
    drive_op(WT, 16'h0021, 32'h55, lat, rdata, wtc, chg);
    total++;
    if (lat !== 6 || wtc !== 5) begin
      bad++;
      $display("FAIL write_miss_op lat=%0d wt_cycles=%0d exp=6/5", lat, wtc);
    end
    scored_read("read_after_write_miss", 16'h0021, 32'h55, 6);
    total++;
    if (miss_count !== 16'd4 || hit_count !== 16'd2) begin
      bad++;
      $display("FAIL write_miss_counters hit=%0d miss=%0d exp=2/4", hit_count, miss_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    int readySeen;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rdwt  = RD;
    cpu_addr  = 16'h0030;
    cpu_wdata = '0;
    @(posedge clk);          // accepting edge
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dbgState !== 2'(FILL)) begin
      bad++;
      $display("FAIL midfill_state got=%0d exp=%0d", dbgState, 2'(FILL));
    end
    @(negedge clk);          // third FILL cycle
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (dbgState !== 2'(IDLE) || cpu_ready !== 1'b0 || mem_rdwt !== RD || mem_addr !== '0) begin
      bad++;
      $display("FAIL midfill_abort state=%0d ready=%b rdwt=%b addr=%h exp=0/0/0/0",
               dbgState, cpu_ready, mem_rdwt, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    readySeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_ready) readySeen++;
    end
    total++;
    if (readySeen !== 0 || miss_count !== 16'd0) begin
      bad++;
      $display("FAIL midfill_no_response ready_pulses=%0d miss=%0d exp=0/0", readySeen, miss_count);
    end
    scored_read("after_abort_0030", 16'h0030, 32'h130, 6);
    scored_read("after_abort_0010", 16'h0010, 32'hAB, 6);
    total++;
    if (miss_count !== 16'd2 || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL after_abort_counters hit=%0d miss=%0d exp=0/2", hit_count, miss_count);
    end
  endtask

  // Random reads/writes over a small address window with index conflicts,
  // predicted by a reference cache (valid/tag) and reference memory.
  task automatic test_back_to_back();
    logic          mValid [4];
    logic [13:0]   mTag   [4];
    logic [DW-1:0] refMem [int];
    int            expHits, expMisses;
    logic [AW-1:0] addr;
    logic [1:0]    idx;
    logic [DW-1:0] wd, expData;
    int            lat, wtc, chg;
    logic [DW-1:0] rdata;
    bit            isHit;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = '0;
    end
    expHits = 0;
    expMisses = 0;
    for (int n = 0; n < 24; n++) begin
      addr = 16'h0040 + 16'($urandom_range(0, 7));
      idx  = addr[1:0];
      if ($urandom_range(0, 2) == 0) begin
        wd = $urandom;
        drive_op(WT, addr, wd, lat, rdata, wtc, chg);
        refMem[int'(addr)] = wd;
        total++;
        if (lat !== 6 || wtc !== 5) begin
          bad++;
          $display("FAIL b2b_write addr=%h lat=%0d wt_cycles=%0d exp=6/5", addr, lat, wtc);
        end
      end else begin
        expData = refMem.exists(int'(addr)) ? refMem[int'(addr)] : (32'(addr) + 32'h100);
        isHit   = mValid[idx] && (mTag[idx] == addr[15:2]);
        scored_read("b2b_read", addr, expData, isHit ? 1 : 6);
        if (isHit) begin
          expHits++;
        end else begin
          expMisses++;
          mValid[idx] = 1'b1;
          mTag[idx]   = addr[15:2];
        end
      end
    end
    total++;
    if (hit_count !== 16'(expHits) || miss_count !== 16'(expMisses)) begin
      bad++;
      $display("FAIL b2b_counters hit=%0d miss=%0d exp=%0d/%0d", hit_count, miss_count, expHits, expMisses);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_rdwt  = RD;
    cpu_addr  = '0;
    cpu_wdata = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
